// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stability-counting debouncer.
// Produces a registered clean level, its complement, and edge strobes.
module debounce_sync #(
   parameter int STABLE_COUNT = 50000,
   parameter int CNT_WIDTH    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic doutn,
   output logic rise,
   output logic fall
);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;

   logic                 r_s1;
   logic                 r_s2;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 r_dout;
   logic                 r_doutn;
   logic                 r_rise;
   logic                 r_fall;
   logic                 w_dout_nxt;
   logic                 w_rise_nxt;
   logic                 w_fall_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_state <= IDLE_LOW;
         r_cnt   <= C_ZERO;
         r_dout  <= 1'b0;
         r_doutn <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_s1    <= din;
         r_s2    <= r_s1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_doutn <= ~w_dout_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // Only the synchronised sample r_s2 steers the FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      unique case (r_state)
         IDLE_LOW: begin
            if (r_s2) begin
               w_state_nxt = WAIT_HIGH;
               w_cnt_nxt   = C_ONE;
            end else begin
               w_cnt_nxt   = C_ZERO;
            end
         end
         WAIT_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = IDLE_LOW;
               w_cnt_nxt   = C_ZERO;
            end else if (r_cnt == C_LAST) begin
               w_state_nxt = IDLE_HIGH;
               w_cnt_nxt   = C_ZERO;
               w_dout_nxt  = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = WAIT_LOW;
               w_cnt_nxt   = C_ONE;
            end else begin
               w_cnt_nxt   = C_ZERO;
            end
         end
         WAIT_LOW: begin
            if (r_s2) begin
               w_state_nxt = IDLE_HIGH;
               w_cnt_nxt   = C_ZERO;
            end else if (r_cnt == C_LAST) begin
               w_state_nxt = IDLE_LOW;
               w_cnt_nxt   = C_ZERO;
               w_dout_nxt  = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = C_ZERO;
            w_dout_nxt  = 1'b0;
         end
      endcase
   end

   assign dout  = r_dout;
   assign doutn = r_doutn;
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with STABLE_COUNT=4, CNT_WIDTH=3.
module tb_debounce_sync;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic dout;
   logic doutn;
   logic rise;
   logic fall;

   int errors = 0;
   int checks = 0;

   debounce_sync #(
      .STABLE_COUNT(4),
      .CNT_WIDTH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .dout(dout),
      .doutn(doutn),
      .rise(rise),
      .fall(fall)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      logic exp;
      din = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++;
         if (dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_dout i=%0d got=%b exp=0", i, dout);
         end
         checks++;
         if (doutn !== 1'b1) begin
            errors++;
            $display("FAIL reset_doutn i=%0d got=%b exp=1", i, doutn);
         end
         checks++;
         if (rise !== 1'b0 || fall !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe i=%0d got=%b%b exp=00", i, rise, fall);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         exp = (k >= 6);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL release_dout k=%0d got=%b exp=%b", k, dout, exp);
         end
         exp = (k == 6);
         checks++;
         if (rise !== exp || fall !== 1'b0) begin
            errors++;
            $display("FAIL release_strobe k=%0d got=%b%b exp=%b0",
                     k, rise, fall, exp);
         end
      end
   endtask

   task automatic test_clean();
      logic exp;
      do_reset();
      din = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         exp = (k >= 6);
         checks++;
         if (dout !== exp || doutn !== ~exp) begin
            errors++;
            $display("FAIL clean_rise_lvl k=%0d got=%b%b exp=%b%b",
                     k, dout, doutn, exp, ~exp);
         end
         exp = (k == 6);
         checks++;
         if (rise !== exp || fall !== 1'b0) begin
            errors++;
            $display("FAIL clean_rise_strb k=%0d got=%b%b exp=%b0",
                     k, rise, fall, exp);
         end
      end
      din = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         exp = (k < 6);
         checks++;
         if (dout !== exp || doutn !== ~exp) begin
            errors++;
            $display("FAIL clean_fall_lvl k=%0d got=%b%b exp=%b%b",
                     k, dout, doutn, exp, ~exp);
         end
         exp = (k == 6);
         checks++;
         if (fall !== exp || rise !== 1'b0) begin
            errors++;
            $display("FAIL clean_fall_strb k=%0d got rise=%b fall=%b exp=0 %b",
                     k, rise, fall, exp);
         end
      end
   endtask

   task automatic test_glitch();
      logic exp_d;
      logic exp_r;
      logic exp_f;
      do_reset();
      din = 1'b1;
      step(3);
      din = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         checks++;
         if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
            errors++;
            $display("FAIL glitch3 k=%0d got d=%b r=%b f=%b exp=000",
                     k, dout, rise, fall);
         end
      end
      din = 1'b1;
      step(4);
      din = 1'b0;
      for (int k = 5; k <= 11; k++) begin
         step(1);
         exp_d = (k >= 6 && k <= 9);
         exp_r = (k == 6);
         exp_f = (k == 10);
         checks++;
         if (dout !== exp_d || rise !== exp_r || fall !== exp_f) begin
            errors++;
            $display("FAIL width4 k=%0d got d=%b r=%b f=%b exp=%b%b%b",
                     k, dout, rise, fall, exp_d, exp_r, exp_f);
         end
      end
   endtask

   task automatic test_bounce();
      logic exp;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         din = (i % 2 == 0);
         step(1);
         checks++;
         if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
            errors++;
            $display("FAIL bounce_burst i=%0d got d=%b r=%b f=%b exp=000",
                     i, dout, rise, fall);
         end
      end
      din = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         exp = (k >= 6);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL bounce_dout k=%0d got=%b exp=%b", k, dout, exp);
         end
         exp = (k == 6);
         checks++;
         if (rise !== exp || fall !== 1'b0) begin
            errors++;
            $display("FAIL bounce_strb k=%0d got=%b%b exp=%b0",
                     k, rise, fall, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic exp;
      do_reset();
      din = 1'b1;
      step(4);
      rst = 1'b1;
      step(1);
      checks++;
      if (dout !== 1'b0 || rise !== 1'b0) begin
         errors++;
         $display("FAIL mid_wait_rst got d=%b r=%b exp=00", dout, rise);
      end
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         exp = (k >= 6);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL mid_wait_dout k=%0d got=%b exp=%b", k, dout, exp);
         end
         exp = (k == 6);
         checks++;
         if (rise !== exp) begin
            errors++;
            $display("FAIL mid_wait_rise k=%0d got=%b exp=%b", k, rise, exp);
         end
      end
      rst = 1'b1;
      step(1);
      checks++;
      if (dout !== 1'b0 || doutn !== 1'b1 || fall !== 1'b0) begin
         errors++;
         $display("FAIL mid_high_rst got d=%b dn=%b f=%b exp=010",
                  dout, doutn, fall);
      end
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         exp = (k >= 6);
         checks++;
         if (dout !== exp || fall !== 1'b0 || rise !== (k == 6)) begin
            errors++;
            $display("FAIL mid_high_after k=%0d got d=%b r=%b f=%b exp=%b%b0",
                     k, dout, rise, fall, exp, (k == 6));
         end
      end
   endtask

   task automatic test_complement();
      logic prev;
      do_reset();
      prev = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) din = ~din;
         step(1);
         checks++;
         if (doutn !== ~dout) begin
            errors++;
            $display("FAIL compl i=%0d got dout=%b doutn=%b", i, dout, doutn);
         end
         checks++;
         if (rise === 1'b1 && fall === 1'b1) begin
            errors++;
            $display("FAIL both_strobes i=%0d got rise=1 fall=1 exp=not both", i);
         end
         checks++;
         if (prev && (rise || fall)) begin
            errors++;
            $display("FAIL consec_strobe i=%0d got r=%b f=%b exp=00",
                     i, rise, fall);
         end
         prev = rise | fall;
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_glitch();
      test_bounce();
      test_reset_mid();
      test_complement();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
